// File: rtl/logic_mux_unit.sv
// logic_mux_unit: registered eight-way bitwise operation stage with a
// valid/ready result port. With LOGIC_MUX_SWEEP_EN defined, a beat accepted
// with sweep=1 emits all eight operations (op 0..7) on the captured operands.
// Without it, sweep is ignored and every accept produces a single result.
module logic_mux_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             sweep,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       out_op,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        SWEEP  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [2:0]       out_op_nxt;
    logic             last, accept;

    // Bitwise operation table, no carries between bits.
    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        case (o)
            3'd0:    apply_op = x | y;
            3'd1:    apply_op = ~(x | y);
            3'd2:    apply_op = x & y;
            3'd3:    apply_op = ~(x & y);
            3'd4:    apply_op = x ^ y;
            3'd5:    apply_op = ~(x ^ y);
            3'd6:    apply_op = x;
            default: apply_op = y;
        endcase
    endfunction

`ifdef LOGIC_MUX_SWEEP_EN
    logic [2:0] k, k_nxt;

    assign last = (state == SINGLE) || ((state == SWEEP) && (k == 3'd7));
    assign busy = (state == SWEEP) && (k != 3'd7);
`else
    // sweep has no function in this build; keep it visibly consumed.
    logic sweep_unused;
    assign sweep_unused = sweep;

    assign last = (state == SINGLE);
    assign busy = 1'b0;
`endif

    assign out_valid = (state != IDLE);
    // Ready depends only on the held beat and the consumer, never on in_valid.
    assign in_ready  = !out_valid || (out_ready && last);
    assign accept    = in_valid && in_ready;

    // State register plus captured operands and result; async reset aborts any sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            out_op <= 3'd0;
`ifdef LOGIC_MUX_SWEEP_EN
            k      <= 3'd0;
`endif
        end else begin
            state  <= state_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            result <= result_nxt;
            out_op <= out_op_nxt;
`ifdef LOGIC_MUX_SWEEP_EN
            k      <= k_nxt;
`endif
        end
    end

    // Next state: a new accept wins (back-to-back), else advance or retire the held beat.
    always_comb begin
        state_nxt  = state;
        a_nxt      = a_q;
        b_nxt      = b_q;
        result_nxt = result;
        out_op_nxt = out_op;
`ifdef LOGIC_MUX_SWEEP_EN
        k_nxt      = k;
`endif
        if (accept) begin
            a_nxt = a;
            b_nxt = b;
`ifdef LOGIC_MUX_SWEEP_EN
            if (sweep) begin
                state_nxt  = SWEEP;
                k_nxt      = 3'd0;
                result_nxt = apply_op(3'd0, a, b);
                out_op_nxt = 3'd0;
            end else begin
                state_nxt  = SINGLE;
                k_nxt      = 3'd0;
                result_nxt = apply_op(op, a, b);
                out_op_nxt = op;
            end
`else
            state_nxt  = SINGLE;
            result_nxt = apply_op(op, a, b);
            out_op_nxt = op;
`endif
        end else if (out_valid && out_ready) begin
`ifdef LOGIC_MUX_SWEEP_EN
            if ((state == SWEEP) && (k != 3'd7)) begin
                k_nxt      = k + 3'd1;
                result_nxt = apply_op(k + 3'd1, a_q, b_q);
                out_op_nxt = k + 3'd1;
            end else begin
                state_nxt  = IDLE;
                k_nxt      = 3'd0;
                result_nxt = '0;
                out_op_nxt = 3'd0;
            end
`else
            state_nxt  = IDLE;
            result_nxt = '0;
            out_op_nxt = 3'd0;
`endif
        end
    end

endmodule

// File: tb/tb_logic_mux_unit.sv
// tb_logic_mux_unit: directed test-plan cases plus a randomized run, all
// checked against a queue-of-beats reference model.
module tb_logic_mux_unit;

    localparam int WIDTH = 4;

    logic             clk, rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    logic             sweep;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       out_op;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] res;
    } beat_t;

    // Remaining output beats, head is the one currently presented.
    beat_t q[$];

    logic_mux_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .sweep(sweep),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_op(out_op), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input int o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            int s;
            s = int'(x[i]) + int'(y[i]);
            case (o)
                0: r[i] = (s >= 1);
                1: r[i] = (s == 0);
                2: r[i] = (s == 2);
                3: r[i] = (s != 2);
                4: r[i] = (s == 1);
                5: r[i] = (s != 1);
                6: r[i] = x[i];
                default: r[i] = y[i];
            endcase
        end
        return r;
    endfunction

    // One clock: drive at negedge, check outputs, then apply the handshake to the model.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic [2:0] top, input logic tsw, input logic tr);
        logic exp_rdy, acc, pop;
        beat_t bt;
        in_valid = iv; a = ta; b = tb; op = top; sweep = tsw; out_ready = tr;
        #1;
        exp_rdy = (q.size() == 0) || (tr && q.size() == 1);
        chk("out_valid", out_valid, q.size() > 0);
        chk("result", result, (q.size() > 0) ? q[0].res : '0);
        chk("out_op", out_op, (q.size() > 0) ? q[0].op : 3'd0);
        chk("busy", busy, q.size() > 1);
        chk("in_ready", in_ready, exp_rdy);
        acc = iv && exp_rdy;
        pop = (q.size() > 0) && tr;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
`ifdef LOGIC_MUX_SWEEP_EN
            if (tsw) begin
                for (int i = 0; i < 8; i++) begin
                    bt.op = 3'(i); bt.res = ref_op(i, ta, tb); q.push_back(bt);
                end
            end else begin
                bt.op = top; bt.res = ref_op(int'(top), ta, tb); q.push_back(bt);
            end
`else
            bt.op = top; bt.res = ref_op(int'(top), ta, tb); q.push_back(bt);
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] sweep_exp [8];
        sweep_exp = '{4'b1110, 4'b0001, 4'b1000, 4'b0111, 4'b0110, 4'b1001, 4'b1100, 4'b1010};

        rst = 1'b1; in_valid = 0; a = 0; b = 0; op = 0; sweep = 0; out_ready = 0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        cycle(0, 4'hF, 4'hF, 3'd3, 0, 1);
        cycle(0, 4'h0, 4'h5, 3'd1, 1, 0);

        // Single op with backpressure for three clocks.
        cycle(1, 4'b1100, 4'b1010, 3'd1, 0, 0);
        chk("single_result", result, 4'b0001);
        chk("single_op", out_op, 1);
        for (int i = 0; i < 3; i++) cycle(0, 4'h3, 4'h3, 3'd5, 0, 0);
        chk("single_hold", result, 4'b0001);
        cycle(0, 4'h0, 4'h0, 3'd0, 0, 1);
        chk("single_clear", out_valid, 0);

        // Back-to-back singles.
        cycle(1, 4'b1100, 4'b1010, 3'd0, 0, 1);
        chk("b2b_or", result, 4'b1110);
        cycle(1, 4'b1100, 4'b1010, 3'd2, 0, 1);
        chk("b2b_and", result, 4'b1000);
        cycle(1, 4'b1100, 4'b1010, 3'd4, 0, 1);
        chk("b2b_xor", result, 4'b0110);
        cycle(0, 4'h0, 4'h0, 3'd0, 0, 1);

`ifdef LOGIC_MUX_SWEEP_EN
        // Full sweep; operand changes during the sweep must be ignored.
        cycle(1, 4'b1100, 4'b1010, 3'd5, 1, 1);
        for (int i = 0; i < 8; i++) begin
            chk("sweep_op", out_op, i);
            chk("sweep_res", result, sweep_exp[i]);
            chk("sweep_busy", busy, i < 7);
            cycle(0, 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1);
        end
        chk("sweep_done", out_valid, 0);

        // Reset at k=3 aborts the sweep.
        cycle(1, 4'b1100, 4'b1010, 3'd0, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 4'h0, 4'h0, 3'd0, 0, 1);
        chk("pre_rst_k", out_op, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 4'h0, 4'h0, 3'd0, 0, 1);
        cycle(1, 4'b0110, 4'b0011, 3'd3, 0, 1);
        chk("post_rst_single", result, 4'b1101);
`else
        // Sweep request degrades to a single result.
        cycle(1, 4'b1100, 4'b1010, 3'd5, 1, 1);
        chk("nosweep_res", result, 4'b1001);
        chk("nosweep_op", out_op, 5);
        cycle(0, 4'h0, 4'h0, 3'd0, 1, 1);
        chk("nosweep_one", out_valid, 0);
        cycle(1, 4'b1100, 4'b1010, 3'd2, 0, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 4'h0, 4'h0, 3'd0, 0, 1);
`endif

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom));
        for (int i = 0; i < 12; i++) cycle(0, 4'h0, 4'h0, 3'd0, 0, 1);
        chk("drained", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
